// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue in-order instruction buffer with score-board hazard check.
// Holds decoded instruction pairs in a circular buffer. Each cycle it looks at the
// two oldest entries, reads their source status from the score board and issues
// zero, one or two of them. It also writes the score board for issued destinations.
module issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int POS_W = 4,
    parameter int PAY_W = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        flash,
    input  logic [1:0]                  in_valid,
    output logic                        in_ready,
    input  logic [1:0][1:0][4:0]        in_src,
    input  logic [1:0][1:0]             in_src_used,
    input  logic [1:0][4:0]             in_dst,
    input  logic [1:0]                  in_dst_wen,
    input  logic [1:0][1:0]             in_lat,
    input  logic [1:0]                  in_mem,
    input  logic [1:0][PAY_W-1:0]       in_payload,
    output logic [1:0]                  issue_valid,
    output logic [1:0][PAY_W-1:0]       issue_payload,
    output logic [1:0][4:0]             issue_dst,
    output logic [1:0]                  issue_dst_wen,
    output logic [1:0]                  issue_mem,
    output logic [3:0][4:0]             sb_read_addr,
    input  logic [3:0][POS_W-1:0]       sb_pos,
    output logic [1:0]                  sb_write_ena,
    output logic [1:0][4:0]             sb_write_addr,
    output logic [1:0][POS_W-1:0]       sb_write_pos
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    // Buffer storage; contents are qualified by count, so no reset is needed.
    logic [1:0][4:0]   e_src  [DEPTH];
    logic [1:0]        e_used [DEPTH];
    logic [4:0]        e_dst  [DEPTH];
    logic              e_wen  [DEPTH];
    logic [1:0]        e_lat  [DEPTH];
    logic              e_mem  [DEPTH];
    logic [PAY_W-1:0]  e_pay  [DEPTH];

    logic [PTR_W-1:0]  head, tail, head_nx1, tail_nx1;
    logic [CNT_W-1:0]  count, enq_n, deq_n;
    logic              enq_ok;
    logic              rdy0, rdy1, raw, waw, both_mem;
    logic              iss0, iss1;

    // An operand can proceed if it is unused, is r0, or its result is at most one cycle away.
    function automatic logic opnd_rdy(input logic used, input logic [4:0] src,
                                      input logic [POS_W-1:0] pos);
        return !used || (src == 5'd0) || ((pos >> 1) == '0);
    endfunction

    assign head_nx1 = head + PTR_W'(1);
    assign tail_nx1 = tail + PTR_W'(1);
    assign in_ready = (count <= READY_MAX);
    assign enq_ok   = in_ready && !flash;
    assign enq_n    = enq_ok ? (CNT_W'(in_valid[0]) + CNT_W'(in_valid[1])) : '0;
    assign deq_n    = CNT_W'(iss0) + CNT_W'(iss1);

    // Score board reads for the two head entries' sources.
    always_comb begin
        sb_read_addr[0] = e_src[head][0];
        sb_read_addr[1] = e_src[head][1];
        sb_read_addr[2] = e_src[head_nx1][0];
        sb_read_addr[3] = e_src[head_nx1][1];
    end

    // Readiness and intra-pair hazard detection for the two head entries.
    always_comb begin
        rdy0 = opnd_rdy(e_used[head][0], e_src[head][0], sb_pos[0]) &&
               opnd_rdy(e_used[head][1], e_src[head][1], sb_pos[1]);
        rdy1 = opnd_rdy(e_used[head_nx1][0], e_src[head_nx1][0], sb_pos[2]) &&
               opnd_rdy(e_used[head_nx1][1], e_src[head_nx1][1], sb_pos[3]);
        raw  = e_wen[head] && (e_dst[head] != 5'd0) &&
               ((e_used[head_nx1][0] && (e_src[head_nx1][0] == e_dst[head])) ||
                (e_used[head_nx1][1] && (e_src[head_nx1][1] == e_dst[head])));
        waw  = e_wen[head] && e_wen[head_nx1] && (e_dst[head] != 5'd0) &&
               (e_dst[head] == e_dst[head_nx1]);
        both_mem = e_mem[head] && e_mem[head_nx1];
        iss0 = !stall && !flash && (count != '0) && rdy0;
        iss1 = iss0 && (count > CNT_W'(1)) && rdy1 && !raw && !waw && !both_mem;
    end

    // Issue and score board write outputs; every field is zero for a slot that does not issue.
    always_comb begin
        issue_valid   = '0;
        issue_payload = '0;
        issue_dst     = '0;
        issue_dst_wen = '0;
        issue_mem     = '0;
        sb_write_ena  = '0;
        sb_write_addr = '0;
        sb_write_pos  = '0;
        if (iss0) begin
            issue_valid[0]   = 1'b1;
            issue_payload[0] = e_pay[head];
            issue_dst[0]     = e_dst[head];
            issue_dst_wen[0] = e_wen[head];
            issue_mem[0]     = e_mem[head];
            sb_write_ena[0]  = e_wen[head] && (e_dst[head] != 5'd0);
            sb_write_addr[0] = e_dst[head];
            sb_write_pos[0]  = POS_W'(1) << e_lat[head];
        end
        if (iss1) begin
            issue_valid[1]   = 1'b1;
            issue_payload[1] = e_pay[head_nx1];
            issue_dst[1]     = e_dst[head_nx1];
            issue_dst_wen[1] = e_wen[head_nx1];
            issue_mem[1]     = e_mem[head_nx1];
            sb_write_ena[1]  = e_wen[head_nx1] && (e_dst[head_nx1] != 5'd0);
            sb_write_addr[1] = e_dst[head_nx1];
            sb_write_pos[1]  = POS_W'(1) << e_lat[head_nx1];
        end
    end

    // Write accepted decode slots into the buffer at tail and tail+1.
    always_ff @(posedge clk) begin
        if (enq_ok && in_valid[0]) begin
            e_src[tail]  <= in_src[0];
            e_used[tail] <= in_src_used[0];
            e_dst[tail]  <= in_dst[0];
            e_wen[tail]  <= in_dst_wen[0];
            e_lat[tail]  <= in_lat[0];
            e_mem[tail]  <= in_mem[0];
            e_pay[tail]  <= in_payload[0];
        end
        if (enq_ok && in_valid[1]) begin
            e_src[tail_nx1]  <= in_src[1];
            e_used[tail_nx1] <= in_src_used[1];
            e_dst[tail_nx1]  <= in_dst[1];
            e_wen[tail_nx1]  <= in_dst_wen[1];
            e_lat[tail_nx1]  <= in_lat[1];
            e_mem[tail_nx1]  <= in_mem[1];
            e_pay[tail_nx1]  <= in_payload[1];
        end
    end

    // Pointer and occupancy update; flush empties the buffer and rewinds both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + deq_n[PTR_W-1:0];
            tail  <= tail + enq_n[PTR_W-1:0];
            count <= count + enq_n - deq_n;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed table-driven bench for issue_ctrl, plus a hand-written
// asynchronous-reset sequence.
module tb_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int POS_W = 4;
    localparam int PAY_W = 64;

    typedef struct packed {
        logic [4:0] dst;
        logic       wen;
        logic [4:0] s0;
        logic       u0;
        logic [4:0] s1;
        logic       u1;
        logic [1:0] lat;
        logic       mem;
    } ins_t;

    typedef struct {
        ins_t                  i0;
        ins_t                  i1;
        logic [1:0]            v;
        logic                  st;
        logic                  fl;
        logic [3:0][POS_W-1:0] pos;
        logic [1:0]            eiv;
        logic [1:0]            ewe;
        logic                  erdy;
        logic [1:0][4:0]       edst;
        logic [1:0][POS_W-1:0] ewpos;
        string                 nm;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst_n, stall, flash;
    logic [1:0]             in_valid;
    logic                   in_ready;
    logic [1:0][1:0][4:0]   in_src;
    logic [1:0][1:0]        in_src_used;
    logic [1:0][4:0]        in_dst;
    logic [1:0]             in_dst_wen;
    logic [1:0][1:0]        in_lat;
    logic [1:0]             in_mem;
    logic [1:0][PAY_W-1:0]  in_payload;
    logic [1:0]             issue_valid;
    logic [1:0][PAY_W-1:0]  issue_payload;
    logic [1:0][4:0]        issue_dst;
    logic [1:0]             issue_dst_wen;
    logic [1:0]             issue_mem;
    logic [3:0][4:0]        sb_read_addr;
    logic [3:0][POS_W-1:0]  sb_pos;
    logic [1:0]             sb_write_ena;
    logic [1:0][4:0]        sb_write_addr;
    logic [1:0][POS_W-1:0]  sb_write_pos;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    issue_ctrl #(.DEPTH(DEPTH), .POS_W(POS_W), .PAY_W(PAY_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flash(flash),
        .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src),
        .in_src_used(in_src_used), .in_dst(in_dst), .in_dst_wen(in_dst_wen),
        .in_lat(in_lat), .in_mem(in_mem), .in_payload(in_payload),
        .issue_valid(issue_valid), .issue_payload(issue_payload),
        .issue_dst(issue_dst), .issue_dst_wen(issue_dst_wen), .issue_mem(issue_mem),
        .sb_read_addr(sb_read_addr), .sb_pos(sb_pos), .sb_write_ena(sb_write_ena),
        .sb_write_addr(sb_write_addr), .sb_write_pos(sb_write_pos)
    );

    function automatic logic [PAY_W-1:0] mk_pay(input logic [4:0] d);
        return {32'hC0DE_0000, 27'd0, d};
    endfunction

    // Instruction d <- a op b; a zero source is marked unused.
    function automatic ins_t I(input int d, input int a, input int b, input int l, input bit m);
        ins_t x;
        x.dst = 5'(d); x.wen = 1'b1;
        x.s0 = 5'(a);  x.u0 = (a != 0);
        x.s1 = 5'(b);  x.u1 = (b != 0);
        x.lat = 2'(l); x.mem = m;
        return x;
    endfunction

    function automatic vec_t V(input ins_t i0, input ins_t i1, input logic [1:0] v,
                               input logic st, input logic fl, input logic [15:0] pos,
                               input logic [1:0] eiv, input logic [1:0] ewe, input logic erdy,
                               input logic [9:0] edst, input logic [7:0] ewpos, input string nm);
        vec_t t;
        t.i0 = i0; t.i1 = i1; t.v = v; t.st = st; t.fl = fl; t.pos = pos;
        t.eiv = eiv; t.ewe = ewe; t.erdy = erdy; t.edst = edst; t.ewpos = ewpos; t.nm = nm;
        return t;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", nm, fld, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        ins_t x;
        in_valid = t.v; stall = t.st; flash = t.fl; sb_pos = t.pos;
        for (int k = 0; k < 2; k++) begin
            x = (k == 0) ? t.i0 : t.i1;
            in_src[k][0]   = x.s0;
            in_src[k][1]   = x.s1;
            in_src_used[k] = {x.u1, x.u0};
            in_dst[k]      = x.dst;
            in_dst_wen[k]  = x.wen;
            in_lat[k]      = x.lat;
            in_mem[k]      = x.mem;
            in_payload[k]  = mk_pay(x.dst);
        end
    endtask

    task automatic check_vec(input vec_t t);
        chk(t.nm, "issue_valid", 64'(issue_valid), 64'(t.eiv));
        chk(t.nm, "sb_write_ena", 64'(sb_write_ena), 64'(t.ewe));
        chk(t.nm, "in_ready", 64'(in_ready), 64'(t.erdy));
        for (int k = 0; k < 2; k++) begin
            chk(t.nm, "issue_dst", 64'(issue_dst[k]), t.eiv[k] ? 64'(t.edst[k]) : 64'd0);
            chk(t.nm, "issue_payload", issue_payload[k], t.eiv[k] ? mk_pay(t.edst[k]) : 64'd0);
            if (t.ewe[k]) begin
                chk(t.nm, "sb_write_addr", 64'(sb_write_addr[k]), 64'(t.edst[k]));
                chk(t.nm, "sb_write_pos", 64'(sb_write_pos[k]), 64'(t.ewpos[k]));
            end
        end
    endtask

    initial begin
        ins_t N;
        N = '0;
        //                 i0                 i1                 v    st fl pos      eiv  ewe  rdy edst             ewpos
        vecs.push_back(V(I(1,2,3,0,0),   I(4,5,6,1,0),   2'b11,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp1_enq"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b11,2'b11,1,{5'd4,5'd1},  8'h21,"tp1_pair"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp1_empty"));
        vecs.push_back(V(I(1,2,0,0,0),   I(3,1,0,0,0),   2'b11,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp2_enq"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b01,2'b01,1,{5'd0,5'd1},  8'h01,"tp2_raw"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0001,2'b01,2'b01,1,{5'd0,5'd3},  8'h01,"tp2_second"));
        vecs.push_back(V(I(8,7,0,2,0),   N,              2'b01,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp3_enq"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0004,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp3_pos4"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0002,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp3_pos2"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0001,2'b01,2'b01,1,{5'd0,5'd8},  8'h04,"tp3_pos1"));
        vecs.push_back(V(I(9,0,0,0,1),   I(10,0,0,1,1),  2'b11,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp4_enq_mem"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b01,2'b01,1,{5'd0,5'd9},  8'h01,"tp4_mem_a"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b01,2'b01,1,{5'd0,5'd10}, 8'h02,"tp4_mem_b"));
        vecs.push_back(V(I(11,0,0,0,0),  I(12,0,0,0,0),  2'b11,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp4_enq"));
        vecs.push_back(V(I(13,0,0,0,0),  N,              2'b01,1,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp4_stall1"));
        vecs.push_back(V(N,              N,              2'b00,1,0,16'h0000,2'b00,2'b00,0,{5'd0,5'd0},  8'h00,"tp4_stall2"));
        vecs.push_back(V(I(14,0,0,0,0),  I(15,0,0,0,0),  2'b11,1,0,16'h0000,2'b00,2'b00,0,{5'd0,5'd0},  8'h00,"tp4_stall3"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b11,2'b11,0,{5'd12,5'd11},8'h11,"tp4_unstall"));
        vecs.push_back(V(I(16,0,0,0,0),  I(17,0,0,0,0),  2'b11,1,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp5_fill"));
        vecs.push_back(V(I(14,0,0,0,0),  I(15,0,0,0,0),  2'b11,1,1,16'h0000,2'b00,2'b00,0,{5'd0,5'd0},  8'h00,"tp5_flash_full"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp5_after_flash"));
        vecs.push_back(V(I(18,0,0,0,0),  I(19,0,0,0,0),  2'b11,0,1,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp5_flash_enq"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp5_enq_dropped"));
        vecs.push_back(V(I(0,1,0,0,0),   N,              2'b01,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"tp6_enq_r0"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b01,2'b00,1,{5'd0,5'd0},  8'h00,"tp6_r0_dst"));
        vecs.push_back(V(I(20,0,0,0,0),  I(20,0,0,1,0),  2'b11,0,0,16'h0000,2'b00,2'b00,1,{5'd0,5'd0},  8'h00,"waw_enq"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b01,2'b01,1,{5'd0,5'd20}, 8'h01,"waw_a"));
        vecs.push_back(V(N,              N,              2'b00,0,0,16'h0000,2'b01,2'b01,1,{5'd0,5'd20}, 8'h02,"waw_b"));

        // Reset state
        rst_n = 1'b0;
        drive(V(N, N, 2'b00, 0, 0, 16'h0000, 2'b00, 2'b00, 1, 10'd0, 8'd0, "idle"));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", "issue_valid", 64'(issue_valid), 64'd0);
        chk("reset", "sb_write_ena", 64'(sb_write_ena), 64'd0);
        chk("reset", "in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            @(negedge clk);
            check_vec(vecs[i]);
        end

        // Asynchronous reset while two entries are held by stall
        @(posedge clk);
        #1 drive(V(I(21,2,3,0,0), I(22,4,5,0,0), 2'b11, 1, 0, 16'h0000, 2'b00, 2'b00, 1, 10'd0, 8'd0, "rst_enq"));
        @(posedge clk);
        #1 in_valid = 2'b00;
        #1 chk("rst_seq", "sb_read_addr", 64'(sb_read_addr), 64'({5'd5, 5'd4, 5'd3, 5'd2}));
        chk("rst_seq", "issue_valid_stalled", 64'(issue_valid), 64'd0);
        stall = 1'b0;
        #1 chk("rst_seq", "issue_valid_queued", 64'(issue_valid), 64'd3);
        rst_n = 1'b0;
        #1 chk("rst_seq", "issue_valid_in_reset", 64'(issue_valid), 64'd0);
        chk("rst_seq", "sb_write_ena_in_reset", 64'(sb_write_ena), 64'd0);
        chk("rst_seq", "in_ready_in_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_seq", "issue_valid_after", 64'(issue_valid), 64'd0);
        chk("rst_seq", "in_ready_after", 64'(in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
